serial_full_subtractor: RTL

- Bit-serial, multi-cycle subtractor. Computes diff = a - b - bin over WIDTH clock cycles using one full-subtractor cell and a registered borrow.
- It is the inverse-operation companion of the team's combinational full-adder datapath. It serves area-constrained arithmetic paths where a WIDTH-bit ripple subtractor is too large.
- Operands and result move through a start/busy/done handshake.

---
 rtl/serial_full_subtractor.sv | 85 ++++++++
 1 files changed

// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH cycles with a single
// full-subtractor cell and a registered borrow, behind a start/busy/done handshake.
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d, br_next, last;

    // One full-subtractor cell operating on the current LSBs
    assign d       = a_sh[0] ^ b_sh[0] ^ br;
    assign br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    assign last    = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = BUSY;
            BUSY:    if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            r_sh <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh <= a;
                    b_sh <= b;
                    br   <= bin;
                    cnt  <= '0;
                    r_sh <= '0;
                end
                BUSY: begin
                    r_sh <= {d, r_sh[WIDTH-1:1]};
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    br   <= br_next;
                    cnt  <= cnt + 1'b1;
                    // The final bit goes straight into diff so the result lands at the completing edge
                    if (last) begin
                        diff <= {d, r_sh[WIDTH-1:1]};
                        bout <= br_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == BUSY);
    assign done = (state == DONE);

endmodule
